// File: rtl/cat_rec_apb_slave.sv
// APB3 responder for the cat recognizer: register bank (CTRL/STAT/BIAS) plus a memory window.
// Optional macro CAT_REC_APB_PSLVERR_EN enables PSLVERR on unmapped/busy-rejected accesses.
module cat_rec_apb_slave #(
  parameter int Amba_Word        = 24,
  parameter int Amba_Addr_Depth  = 13,
  parameter int Weight_precision = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [Amba_Addr_Depth-1:0]   PADDR,
  input  logic [Amba_Word-1:0]         PWDATA,
  output logic [Amba_Word-1:0]         PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic                         mem_we,
  output logic                         mem_re,
  output logic [Amba_Addr_Depth-2:0]   mem_addr,
  output logic [Amba_Word-1:0]         mem_wdata,
  input  logic [Amba_Word-1:0]         mem_rdata,
  output logic                         core_start,
  output logic [Weight_precision-1:0]  core_bias,
  input  logic                         core_busy,
  input  logic                         core_done,
  input  logic                         core_result
);

  localparam int MA = Amba_Addr_Depth - 1;
  localparam logic [MA-1:0] REG_CTRL = MA'(32'd0);
  localparam logic [MA-1:0] REG_STAT = MA'(32'd1);
  localparam logic [MA-1:0] REG_BIAS = MA'(32'd2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACCESS  = 2'd2,
    MEMWAIT = 2'd3
  } state_t;

  state_t                      state_r, state_nxt_s;
  logic                        is_mem_s, mem_rd_s, ctrl_wr_s, bias_wr_s;
  logic                        enter_acc_s, start_fire_s, ready_nxt_s, err_s;
  logic [MA-1:0]               reg_idx_s;
  logic [Amba_Word-1:0]        reg_rdata_s;
  logic [Amba_Word-1:0]        prdata_r, mem_wdata_r;
  logic [MA-1:0]               mem_addr_r;
  logic                        pready_r, pslverr_r, mem_we_r, mem_re_r, core_start_r;
  logic                        done_r, result_r;
  logic [Weight_precision-1:0] bias_r;

  assign is_mem_s     = PADDR[MA];
  assign reg_idx_s    = PADDR[MA-1:0];
  assign mem_rd_s     = is_mem_s & ~PWRITE;
  assign ctrl_wr_s    = ~is_mem_s & PWRITE & (reg_idx_s == REG_CTRL);
  assign bias_wr_s    = ~is_mem_s & PWRITE & (reg_idx_s == REG_BIAS);
  assign enter_acc_s  = (state_r == SETUP) & PSEL;
  assign start_fire_s = (state_r == ACCESS) & PSEL & ctrl_wr_s & PWDATA[0] & ~core_busy;

`ifdef CAT_REC_APB_PSLVERR_EN
  logic mapped_s;
  assign mapped_s = (reg_idx_s <= REG_BIAS);
  assign err_s    = (~is_mem_s & ~mapped_s)
                  | (is_mem_s & PWRITE & core_busy)
                  | (ctrl_wr_s & PWDATA[0] & core_busy);
`else
  assign err_s = 1'b0;
`endif

  // Register bank read mux
  always_comb begin
    reg_rdata_s = {Amba_Word{1'b0}};
    case (reg_idx_s)
      REG_CTRL: reg_rdata_s = {Amba_Word{1'b0}};
      REG_STAT: reg_rdata_s = {{(Amba_Word-3){1'b0}}, result_r, done_r, core_busy};
      REG_BIAS: reg_rdata_s = {{(Amba_Word-Weight_precision){1'b0}}, bias_r};
      default:  reg_rdata_s = {Amba_Word{1'b0}};
    endcase
  end

  // Transfer FSM next-state; a PSEL drop abandons the transfer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (PSEL && !PENABLE) state_nxt_s = SETUP;
        else                  state_nxt_s = IDLE;
      end
      SETUP: begin
        if (PSEL) state_nxt_s = ACCESS;
        else      state_nxt_s = IDLE;
      end
      ACCESS: begin
        if (!PSEL)                state_nxt_s = IDLE;
        else if (mem_rd_s)        state_nxt_s = MEMWAIT;
        else if (!PENABLE)        state_nxt_s = SETUP;
        else                      state_nxt_s = IDLE;
      end
      MEMWAIT: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with ACCESS/MEMWAIT
  assign ready_nxt_s = (enter_acc_s & ~mem_rd_s) | (state_nxt_s == MEMWAIT);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Bus-side handshake, strobes and read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pready_r    <= 1'b0;
      pslverr_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_re_r    <= 1'b0;
      mem_addr_r  <= {MA{1'b0}};
      mem_wdata_r <= {Amba_Word{1'b0}};
      prdata_r    <= {Amba_Word{1'b0}};
    end else begin
      pready_r  <= ready_nxt_s;
      pslverr_r <= enter_acc_s & ~mem_rd_s & err_s;
      mem_we_r  <= enter_acc_s & is_mem_s & PWRITE & ~core_busy;
      mem_re_r  <= enter_acc_s & mem_rd_s;
      if (enter_acc_s) begin
        mem_addr_r  <= PADDR[MA-1:0];
        mem_wdata_r <= PWDATA;
      end
      if (enter_acc_s && !is_mem_s && !PWRITE) prdata_r <= reg_rdata_s;
      else if (state_r == MEMWAIT)             prdata_r <= mem_rdata;
    end
  end

  // Core control: bias, start pulse, done/result latch (done beats a same-cycle start)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias_r       <= {Weight_precision{1'b0}};
      core_start_r <= 1'b0;
      done_r       <= 1'b0;
      result_r     <= 1'b0;
    end else begin
      core_start_r <= start_fire_s;
      if (enter_acc_s && bias_wr_s) bias_r <= PWDATA[Weight_precision-1:0];
      if (core_done) begin
        done_r   <= 1'b1;
        result_r <= core_result;
      end else if (start_fire_s) begin
        done_r <= 1'b0;
      end
    end
  end

  // Memory data is only valid during MEMWAIT, so it is forwarded there and held afterwards
  assign PRDATA     = (state_r == MEMWAIT) ? mem_rdata : prdata_r;
  assign PREADY     = pready_r;
  assign PSLVERR    = pslverr_r;
  assign mem_we     = mem_we_r;
  assign mem_re     = mem_re_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign core_start = core_start_r;
  assign core_bias  = bias_r;

endmodule

// File: tb/tb_cat_rec_apb_slave.sv
// Directed self-checking bench for cat_rec_apb_slave.
module tb_cat_rec_apb_slave;
`ifdef CAT_REC_APB_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic        clk, rst, PSEL, PENABLE, PWRITE;
  logic [12:0] PADDR;
  logic [23:0] PWDATA, PRDATA, mem_wdata, mem_rdata, mem_word;
  logic        PREADY, PSLVERR, mem_we, mem_re, core_start, core_busy, core_done, core_result;
  logic [11:0] mem_addr;
  logic [4:0]  core_bias;

  int cmp = 0;
  int mis = 0;

  logic [23:0] rd, wd;
  logic [11:0] wa;
  int          wt;
  logic        swe, sre, er, sa, f1, f2;

  cat_rec_apb_slave dut (
    .clk(clk), .rst(rst), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .core_start(core_start), .core_bias(core_bias),
    .core_busy(core_busy), .core_done(core_done), .core_result(core_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory answers one cycle after the read strobe
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem_word;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one APB transfer; called #1 after a rising edge
  task automatic apb_xfer(input logic wr, input logic [12:0] addr, input logic [23:0] data,
                          input logic done_at_ready,
                          output logic [23:0] rdata, output int waits, output logic saw_we,
                          output logic saw_re, output logic [11:0] we_addr,
                          output logic [23:0] we_data, output logic err, output logic start_after);
    saw_we = 1'b0; saw_re = 1'b0; we_addr = 12'h000; we_data = 24'h000000; waits = 0;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (mem_we) begin saw_we = 1'b1; we_addr = mem_addr; we_data = mem_wdata; end
      if (mem_re) saw_re = 1'b1;
      if (PREADY) break;
      waits++;
    end
    rdata = PRDATA;
    err   = PSLVERR;
    if (done_at_ready) begin core_done = 1'b1; core_result = 1'b0; end
    @(posedge clk); #1;
    core_done = 1'b0;
    start_after = core_start;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    rst = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 13'h0000;
    PWDATA = 24'h000000; core_busy = 1'b0; core_done = 1'b0; core_result = 1'b0;
    mem_rdata = 24'h000000; mem_word = 24'h000000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_prdata", {8'd0, PRDATA}, 32'd0);
    chk("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_start", {31'd0, core_start}, 32'd0);
    chk("rst_bias", {27'd0, core_bias}, 32'd0);
    chk("rst_slverr", {31'd0, PSLVERR}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // memory write, idle core
    apb_xfer(1'b1, 13'h1005, 24'hABCDEF, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("mw_waits", wt, 32'd0);
    chk("mw_we", {31'd0, swe}, 32'd1);
    chk("mw_addr", {20'd0, wa}, 32'h005);
    chk("mw_data", {8'd0, wd}, 32'hABCDEF);
    chk("mw_err", {31'd0, er}, 32'd0);
    chk("mw_we_after", {31'd0, mem_we}, 32'd0);

    // memory read, one wait state
    mem_word = 24'h123456;
    apb_xfer(1'b0, 13'h1005, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("mr_waits", wt, 32'd1);
    chk("mr_re", {31'd0, sre}, 32'd1);
    chk("mr_no_we", {31'd0, swe}, 32'd0);
    chk("mr_data", {8'd0, rd}, 32'h123456);
    chk("mr_hold", {8'd0, PRDATA}, 32'h123456);

    // BIAS write/readback, including masking of upper bits
    apb_xfer(1'b1, 13'h0002, 24'h00001F, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("bias_waits", wt, 32'd0);
    chk("bias_out", {27'd0, core_bias}, 32'h1F);
    apb_xfer(1'b0, 13'h0002, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("bias_rd", {8'd0, rd}, 32'h00001F);
    chk("bias_rd_waits", wt, 32'd0);
    apb_xfer(1'b1, 13'h0002, 24'hFFFFE3, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("bias_mask_out", {27'd0, core_bias}, 32'h03);
    apb_xfer(1'b0, 13'h0002, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("bias_mask_rd", {8'd0, rd}, 32'h000003);

    // CTRL reads 0, STAT idle, unmapped register
    apb_xfer(1'b0, 13'h0000, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("ctrl_rd", {8'd0, rd}, 32'd0);
    apb_xfer(1'b0, 13'h0001, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("stat_idle", {8'd0, rd}, 32'd0);
    apb_xfer(1'b0, 13'h0005, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("unmapped_rd", {8'd0, rd}, 32'd0);
    chk("unmapped_err", {31'd0, er}, {31'd0, ERR_EN});

    // start, then done with result=1
    apb_xfer(1'b1, 13'h0000, 24'h000001, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("start_pulse", {31'd0, sa}, 32'd1);
    @(posedge clk); #1;
    chk("start_one_cycle", {31'd0, core_start}, 32'd0);
    core_done = 1'b1; core_result = 1'b1;
    @(posedge clk); #1;
    core_done = 1'b0; core_result = 1'b0;
    apb_xfer(1'b0, 13'h0001, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("stat_done_cat", {8'd0, rd}, 32'h6);

    // start and done in the same cycle: done wins, result from core (0)
    apb_xfer(1'b1, 13'h0000, 24'h000001, 1'b1, rd, wt, swe, sre, wa, wd, er, sa);
    chk("start_vs_done_pulse", {31'd0, sa}, 32'd1);
    apb_xfer(1'b0, 13'h0001, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("stat_done_prio", {8'd0, rd}, 32'h2);

    // a plain start clears DONE
    apb_xfer(1'b1, 13'h0000, 24'h000001, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    apb_xfer(1'b0, 13'h0001, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("stat_done_clr", {8'd0, rd}, 32'h0);

    // busy core: memory write dropped, start ignored
    core_busy = 1'b1;
    apb_xfer(1'b1, 13'h1000, 24'h111111, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("busy_mw_we", {31'd0, swe}, 32'd0);
    chk("busy_mw_waits", wt, 32'd0);
    chk("busy_mw_err", {31'd0, er}, {31'd0, ERR_EN});
    apb_xfer(1'b1, 13'h0000, 24'h000001, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("busy_start", {31'd0, sa}, 32'd0);
    chk("busy_start_err", {31'd0, er}, {31'd0, ERR_EN});
    apb_xfer(1'b0, 13'h0001, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("stat_busy", {8'd0, rd}, 32'h1);
    chk("stat_busy_err", {31'd0, er}, 32'd0);
    core_busy = 1'b0;

    // PSEL dropped before the access completes
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 13'h1003; PWDATA = 24'h555555;
    @(posedge clk); #1;
    PSEL = 1'b0;
    @(posedge clk); #1;
    f1 = mem_we | PREADY;
    @(posedge clk); #1;
    f2 = mem_we | PREADY;
    chk("drop_no_strobe", {30'd0, f1, f2}, 32'd0);

    // reset during MEMWAIT
    mem_word = 24'h777777;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 13'h1007;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    chk("memwait_pre_re", {31'd0, mem_re}, 32'd1);
    @(posedge clk); #1;
    chk("memwait_pready", {31'd0, PREADY}, 32'd1);
    chk("memwait_prdata", {8'd0, PRDATA}, 32'h777777);
    rst = 1'b1;
    #1;
    chk("rst_mid_pready", {31'd0, PREADY}, 32'd0);
    chk("rst_mid_prdata", {8'd0, PRDATA}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_idle", {30'd0, PREADY, mem_re}, 32'd0);
    apb_xfer(1'b0, 13'h0002, 24'h000000, 1'b0, rd, wt, swe, sre, wa, wd, er, sa);
    chk("post_rst_bias", {8'd0, rd}, 32'd0);
    chk("post_rst_waits", wt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end
endmodule
